// File: rtl/mem_stage.sv
// Memory stage: waits for in-order data SRAM responses, aligns and extends load data,
// and forwards the packed result to writeback. Drops stale responses after a flush.
module mem_stage #(
    parameter int EM_W   = 196,
    parameter int MW_W   = 191,
    parameter int DROP_W = 2
) (
    input  logic            clk,
    input  logic            rstn,
    output logic            M_allowin,
    input  logic            EM_valid,
    input  logic [EM_W-1:0] EM_BUS,
    input  logic            W_allowin,
    output logic            MW_valid,
    output logic [MW_W-1:0] MW_BUS,
    input  logic            flush,
    input  logic            data_sram_data_ok,
    input  logic [31:0]     data_sram_rdata,
    output logic [38:0]     Mfwd_BUS
);

    localparam logic [DROP_W-1:0] DROP_MAX = {DROP_W{1'b1}};

    logic              r_M_valid;
    logic [EM_W-1:0]   r_EM_BUS_M;
    logic              r_rbuf_valid;
    logic [31:0]       r_rbuf;
    logic [DROP_W-1:0] r_drop_cnt;

    logic [31:0] w_alu_result;
    logic        w_gr_we;
    logic [4:0]  w_dest;
    logic [31:0] w_vaddr;
    logic        w_mem_req;
    logic        w_res_from_mem;
    logic [2:0]  w_load_type;

    logic        w_resp_M;
    logic        w_ready_go;
    logic        w_handoff;
    logic        w_drop_inc;
    logic        w_drop_dec;
    logic [31:0] w_raw;
    logic [7:0]  w_byte;
    logic [15:0] w_half;
    logic [31:0] w_load;
    logic [31:0] w_final;

    assign w_alu_result   = r_EM_BUS_M[163:132];
    assign w_gr_we        = r_EM_BUS_M[131];
    assign w_dest         = r_EM_BUS_M[130:126];
    assign w_vaddr        = r_EM_BUS_M[125:94];
    assign w_mem_req      = r_EM_BUS_M[93];
    assign w_res_from_mem = r_EM_BUS_M[92];
    assign w_load_type    = r_EM_BUS_M[91:89];

    // A data_ok only belongs to M once every stale response has been drained.
    assign w_resp_M   = data_sram_data_ok && (r_drop_cnt == '0);
    assign w_ready_go = !w_mem_req || r_rbuf_valid || w_resp_M;
    assign M_allowin  = !r_M_valid || (w_ready_go && W_allowin);
    assign MW_valid   = r_M_valid && w_ready_go && !flush;
    assign w_handoff  = MW_valid && W_allowin;

    always_ff @(posedge clk) begin
        if (!rstn) begin
            r_M_valid  <= 1'b0;
            r_EM_BUS_M <= '0;
        end else begin
            if (flush) begin
                r_M_valid <= 1'b0;
            end else if (M_allowin) begin
                r_M_valid <= EM_valid;
            end
            if (EM_valid && M_allowin) begin
                r_EM_BUS_M <= EM_BUS;
            end
        end
    end

    // Hold a response that arrived while writeback was stalled.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            r_rbuf_valid <= 1'b0;
            r_rbuf       <= '0;
        end else if (flush || w_handoff) begin
            r_rbuf_valid <= 1'b0;
        end else if (r_M_valid && w_mem_req && w_resp_M && !r_rbuf_valid && !W_allowin) begin
            r_rbuf_valid <= 1'b1;
            r_rbuf       <= data_sram_rdata;
        end
    end

    assign w_drop_inc = flush && r_M_valid && w_mem_req && !r_rbuf_valid && !w_resp_M;
    assign w_drop_dec = data_sram_data_ok && (r_drop_cnt != '0);

    always_ff @(posedge clk) begin
        if (!rstn) begin
            r_drop_cnt <= '0;
        end else if (w_drop_inc && !w_drop_dec && (r_drop_cnt != DROP_MAX)) begin
            r_drop_cnt <= r_drop_cnt + 1'b1;
        end else if (w_drop_dec && !w_drop_inc) begin
            r_drop_cnt <= r_drop_cnt - 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rstn) begin
            assert (r_drop_cnt != DROP_MAX);
        end
    end

    assign w_raw  = r_rbuf_valid ? r_rbuf : data_sram_rdata;
    assign w_half = w_vaddr[1] ? w_raw[31:16] : w_raw[15:0];

    always_comb begin
        w_byte = w_raw[7:0];
        case (w_vaddr[1:0])
            2'd1:    w_byte = w_raw[15:8];
            2'd2:    w_byte = w_raw[23:16];
            2'd3:    w_byte = w_raw[31:24];
            default: w_byte = w_raw[7:0];
        endcase
    end

    // Encodings above LD.HU fall back to a full-word load.
    always_comb begin
        w_load = w_raw;
        case (w_load_type)
            3'b001:  w_load = {{24{w_byte[7]}}, w_byte};
            3'b010:  w_load = {{16{w_half[15]}}, w_half};
            3'b011:  w_load = {24'd0, w_byte};
            3'b100:  w_load = {16'd0, w_half};
            default: w_load = w_raw;
        endcase
    end

    assign w_final = w_res_from_mem ? w_load : w_alu_result;

    assign MW_BUS = {r_EM_BUS_M[195:164], w_final, r_EM_BUS_M[131:94], r_EM_BUS_M[88:0]};

    assign Mfwd_BUS = {r_M_valid && w_gr_we,
                       r_M_valid && w_res_from_mem && !w_ready_go,
                       w_dest,
                       w_final};

endmodule

// File: tb/tb_mem_stage.sv
// Bench for mem_stage: table of single-transaction vectors, hand-written multi-cycle
// sequences, and a randomized run against a transaction-level reference model.
module tb_mem_stage;

    logic         clk;
    logic         rstn;
    logic         M_allowin;
    logic         EM_valid;
    logic [195:0] EM_BUS;
    logic         W_allowin;
    logic         MW_valid;
    logic [190:0] MW_BUS;
    logic         flush;
    logic         data_sram_data_ok;
    logic [31:0]  data_sram_rdata;
    logic [38:0]  Mfwd_BUS;

    int checkCount = 0;
    int passCount  = 0;

    typedef struct {
        logic        memReq;
        logic        resFromMem;
        logic [2:0]  loadType;
        logic [1:0]  off;
        logic [31:0] alu;
        logic [31:0] rdata;
        logic [31:0] expFinal;
    } vec_t;

    vec_t vecs[14];

    mem_stage dut (
        .clk               (clk),
        .rstn              (rstn),
        .M_allowin         (M_allowin),
        .EM_valid          (EM_valid),
        .EM_BUS            (EM_BUS),
        .W_allowin         (W_allowin),
        .MW_valid          (MW_valid),
        .MW_BUS            (MW_BUS),
        .flush             (flush),
        .data_sram_data_ok (data_sram_data_ok),
        .data_sram_rdata   (data_sram_rdata),
        .Mfwd_BUS          (Mfwd_BUS)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic applyStimulus(input logic emValid, input logic [195:0] bus, input logic wAllow,
                                 input logic fl, input logic dok, input logic [31:0] rdata);
        EM_valid          = emValid;
        EM_BUS            = bus;
        W_allowin         = wAllow;
        flush             = fl;
        data_sram_data_ok = dok;
        data_sram_rdata   = rdata;
    endtask

    task automatic checkOutput(input string name, input logic [190:0] act, input logic [190:0] exp);
        checkCount++;
        if (act === exp) begin
            passCount++;
        end else begin
            $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic [195:0] makeBus(input logic [31:0] pc, input logic [31:0] alu,
                                             input logic grWe, input logic [4:0] dest,
                                             input logic [31:0] vaddr, input logic memReq,
                                             input logic resFromMem, input logic [2:0] lt);
        return {pc, alu, grWe, dest, vaddr, memReq, resFromMem, lt,
                1'b0, 8'h00, 1'b0, 14'h0100, 1'b0, 32'h0, 32'h0};
    endfunction

    // Reference load semantics written as plain arithmetic on the selected lane.
    function automatic logic [31:0] refLoad(input logic [2:0] lt, input logic [1:0] off,
                                            input logic [31:0] raw);
        logic [31:0] b;
        logic [31:0] h;
        b = (raw >> (32'(off) * 32'd8)) & 32'h0000_00FF;
        h = (raw >> (32'(off[1]) * 32'd16)) & 32'h0000_FFFF;
        case (lt)
            3'd1:    return (b >= 32'd128)   ? b + 32'hFFFF_FF00 : b;
            3'd2:    return (h >= 32'd32768) ? h + 32'hFFFF_0000 : h;
            3'd3:    return b;
            3'd4:    return h;
            default: return raw;
        endcase
    endfunction

    task automatic idle();
        applyStimulus(1'b0, EM_BUS, 1'b1, 1'b0, 1'b0, 32'h0);
    endtask

    task automatic doReset();
        rstn = 1'b0;
        idle();
        tick();
        tick();
        rstn = 1'b1;
    endtask

    task automatic runOp(input string name, input logic memReq, input logic resFromMem,
                         input logic [2:0] lt, input logic [31:0] vaddr, input logic [31:0] alu,
                         input logic [31:0] rdata, input int waits, input logic [31:0] expFinal);
        logic [195:0] bus;
        bus = makeBus(32'h1C00_0040, alu, 1'b1, 5'd7, vaddr, memReq, resFromMem, lt);
        applyStimulus(1'b1, bus, 1'b1, 1'b0, 1'b0, 32'h0);
        #1;
        checkOutput({name, "_allowin"}, 191'(M_allowin), 191'(1'b1));
        tick();
        for (int i = 0; i < waits; i++) begin
            applyStimulus(1'b0, bus, 1'b1, 1'b0, 1'b0, 32'hAAAA_5555);
            #1;
            checkOutput({name, "_stall"}, 191'(Mfwd_BUS[37]), 191'(1'b1));
            checkOutput({name, "_wait_mwv"}, 191'(MW_valid), 191'(1'b0));
            tick();
        end
        applyStimulus(1'b0, bus, 1'b1, 1'b0, memReq, rdata);
        #1;
        checkOutput({name, "_mwv"}, 191'(MW_valid), 191'(1'b1));
        checkOutput({name, "_final"}, 191'(MW_BUS[158:127]), 191'(expFinal));
        checkOutput({name, "_nostall"}, 191'(Mfwd_BUS[37]), 191'(1'b0));
        tick();
    endtask

    task automatic runRandom(input int cycles);
        logic         mValid;
        logic [195:0] mBus;
        logic         haveResp;
        logic [31:0]  respData;
        int           stale;
        logic         emValid, wAllow, fl, dok;
        logic [31:0]  rdata;
        logic [195:0] bus;
        logic         ex, memReq, resFromMem, respNow, ready, inc, dec, handoff;
        logic         expMwv, expAllow;
        logic [31:0]  raw, fin;
        int           outstanding;

        mValid = 1'b0;
        mBus = '0;
        haveResp = 1'b0;
        respData = '0;
        stale = 0;
        for (int c = 0; c < cycles; c++) begin
            memReq      = mBus[93];
            outstanding = stale + ((mValid && memReq && !haveResp) ? 1 : 0);
            dok    = (outstanding > 0) && ($urandom_range(0, 1) == 0);
            rdata  = $urandom;
            wAllow = ($urandom_range(0, 3) != 0);
            emValid = ($urandom_range(0, 1) == 0);
            respNow = dok && (stale == 0);
            inc = mValid && memReq && !haveResp && !respNow;
            dec = dok && (stale > 0);
            fl  = ($urandom_range(0, 9) == 0);
            if (fl && inc && !dec && stale >= 2) fl = 1'b0;

            ex         = ($urandom_range(0, 7) == 0);
            memReq     = ex ? 1'b0 : 1'($urandom_range(0, 1));
            resFromMem = memReq ? 1'($urandom_range(0, 1)) : 1'b0;
            bus = {$urandom, $urandom, 1'($urandom), 5'($urandom), $urandom, memReq, resFromMem,
                   3'($urandom), ex, 8'($urandom), 1'($urandom), 14'($urandom), 1'($urandom),
                   $urandom, $urandom};
            applyStimulus(emValid, bus, wAllow, fl, dok, rdata);
            #1;

            ready    = !mBus[93] || haveResp || respNow;
            raw      = haveResp ? respData : rdata;
            fin      = mBus[92] ? refLoad(mBus[91:89], mBus[95:94], raw) : mBus[163:132];
            expMwv   = mValid && ready && !fl;
            expAllow = !mValid || (ready && wAllow);

            checkOutput("rnd_mwv", 191'(MW_valid), 191'(expMwv));
            checkOutput("rnd_allowin", 191'(M_allowin), 191'(expAllow));
            checkOutput("rnd_fwd_we", 191'(Mfwd_BUS[38]), 191'(mValid && mBus[131]));
            checkOutput("rnd_stall", 191'(Mfwd_BUS[37]), 191'(mValid && mBus[92] && !ready));
            if (mValid) begin
                checkOutput("rnd_fwd_data", 191'(Mfwd_BUS[36:0]), 191'({mBus[130:126], fin}));
            end
            if (expMwv) begin
                checkOutput("rnd_mwbus", MW_BUS,
                            {mBus[195:164], fin, mBus[131:94], mBus[88:0]});
            end

            handoff = expMwv && wAllow;
            stale = stale + (inc && fl ? 1 : 0) - (dec ? 1 : 0);
            if (fl || handoff) begin
                haveResp = 1'b0;
            end else if (mValid && mBus[93] && respNow) begin
                haveResp = 1'b1;
                respData = rdata;
            end
            if (emValid && expAllow) mBus = bus;
            if (fl) mValid = 1'b0;
            else if (expAllow) mValid = emValid;
            tick();
        end
    endtask

    initial begin
        logic [195:0] bus;

        vecs[0]  = '{1'b1, 1'b1, 3'd0, 2'd0, 32'h0, 32'h89AB_CDEF, 32'h89AB_CDEF};
        vecs[1]  = '{1'b1, 1'b1, 3'd1, 2'd0, 32'h0, 32'h0000_00F0, 32'hFFFF_FFF0};
        vecs[2]  = '{1'b1, 1'b1, 3'd1, 2'd1, 32'h0, 32'h0000_7F00, 32'h0000_007F};
        vecs[3]  = '{1'b1, 1'b1, 3'd1, 2'd2, 32'h0, 32'h00A5_0000, 32'hFFFF_FFA5};
        vecs[4]  = '{1'b1, 1'b1, 3'd3, 2'd2, 32'h0, 32'h00A5_0000, 32'h0000_00A5};
        vecs[5]  = '{1'b1, 1'b1, 3'd3, 2'd1, 32'h0, 32'h0000_FF00, 32'h0000_00FF};
        vecs[6]  = '{1'b1, 1'b1, 3'd2, 2'd0, 32'h0, 32'h1234_8001, 32'hFFFF_8001};
        vecs[7]  = '{1'b1, 1'b1, 3'd2, 2'd2, 32'h0, 32'h7FFF_0000, 32'h0000_7FFF};
        vecs[8]  = '{1'b1, 1'b1, 3'd4, 2'd0, 32'h0, 32'h0000_F00F, 32'h0000_F00F};
        vecs[9]  = '{1'b1, 1'b1, 3'd4, 2'd2, 32'h0, 32'hBEEF_0000, 32'h0000_BEEF};
        vecs[10] = '{1'b1, 1'b1, 3'd5, 2'd1, 32'h0, 32'hAABB_CCDD, 32'hAABB_CCDD};
        vecs[11] = '{1'b1, 1'b1, 3'd7, 2'd3, 32'h0, 32'h0102_0304, 32'h0102_0304};
        vecs[12] = '{1'b1, 1'b0, 3'd0, 2'd0, 32'h00C0_FFEE, 32'hFFFF_FFFF, 32'h00C0_FFEE};
        vecs[13] = '{1'b0, 1'b0, 3'd0, 2'd0, 32'hFFFF_FFFF, 32'h0, 32'hFFFF_FFFF};

        rstn = 1'b0;
        applyStimulus(1'b0, '0, 1'b1, 1'b0, 1'b0, 32'h0);
        tick();
        tick();
        checkOutput("reset_mwv", 191'(MW_valid), 191'(1'b0));
        checkOutput("reset_allowin", 191'(M_allowin), 191'(1'b1));
        checkOutput("reset_fwd_we", 191'(Mfwd_BUS[38]), 191'(1'b0));
        checkOutput("reset_stall", 191'(Mfwd_BUS[37]), 191'(1'b0));
        rstn = 1'b1;

        bus = makeBus(32'h1C00_0000, 32'h1234_5678, 1'b1, 5'd5, 32'h0, 1'b0, 1'b0, 3'd0);
        applyStimulus(1'b1, bus, 1'b1, 1'b0, 1'b0, 32'h0);
        tick();
        idle();
        #1;
        checkOutput("alu_mwv", 191'(MW_valid), 191'(1'b1));
        checkOutput("alu_final", 191'(MW_BUS[158:127]), 191'(32'h1234_5678));
        checkOutput("alu_fwd", 191'(Mfwd_BUS), 191'({1'b1, 1'b0, 5'd5, 32'h1234_5678}));
        tick();

        for (int i = 0; i < 14; i++) begin
            runOp($sformatf("vec%0d", i), vecs[i].memReq, vecs[i].resFromMem, vecs[i].loadType,
                  {30'h0000_0400, vecs[i].off}, vecs[i].alu, vecs[i].rdata, 0, vecs[i].expFinal);
        end

        runOp("ldb", 1'b1, 1'b1, 3'd1, 32'h0000_1003, 32'h0, 32'h80FF_0000, 2, 32'hFFFF_FF80);
        runOp("ldbu", 1'b1, 1'b1, 3'd3, 32'h0000_1003, 32'h0, 32'h80FF_0000, 2, 32'h0000_0080);
        runOp("ldh", 1'b1, 1'b1, 3'd2, 32'h0000_1002, 32'h0, 32'h80FF_0000, 2, 32'hFFFF_80FF);

        bus = makeBus(32'h1C00_0100, 32'h0, 1'b1, 5'd9, 32'h0000_2000, 1'b1, 1'b1, 3'd0);
        applyStimulus(1'b1, bus, 1'b1, 1'b0, 1'b0, 32'h0);
        tick();
        applyStimulus(1'b0, bus, 1'b0, 1'b0, 1'b1, 32'hCAFE_BABE);
        #1;
        checkOutput("rbuf_allowin0", 191'(M_allowin), 191'(1'b0));
        tick();
        for (int i = 0; i < 2; i++) begin
            applyStimulus(1'b0, bus, 1'b0, 1'b0, 1'b0, 32'h1212_3434);
            #1;
            checkOutput("rbuf_hold_allowin", 191'(M_allowin), 191'(1'b0));
            checkOutput("rbuf_hold_final", 191'(Mfwd_BUS[31:0]), 191'(32'hCAFE_BABE));
            checkOutput("rbuf_hold_stall", 191'(Mfwd_BUS[37]), 191'(1'b0));
            tick();
        end
        applyStimulus(1'b0, bus, 1'b1, 1'b0, 1'b0, 32'h1212_3434);
        #1;
        checkOutput("rbuf_mwv", 191'(MW_valid), 191'(1'b1));
        checkOutput("rbuf_allowin", 191'(M_allowin), 191'(1'b1));
        checkOutput("rbuf_final", 191'(MW_BUS[158:127]), 191'(32'hCAFE_BABE));
        tick();

        bus = makeBus(32'h1C00_0200, 32'h0, 1'b1, 5'd10, 32'h0000_3000, 1'b1, 1'b1, 3'd0);
        applyStimulus(1'b1, bus, 1'b1, 1'b0, 1'b0, 32'h0);
        tick();
        applyStimulus(1'b0, bus, 1'b1, 1'b1, 1'b0, 32'h0);
        #1;
        checkOutput("stale_flush_mwv", 191'(MW_valid), 191'(1'b0));
        tick();
        applyStimulus(1'b1, bus, 1'b1, 1'b0, 1'b0, 32'h0);
        #1;
        checkOutput("stale_empty_mwv", 191'(MW_valid), 191'(1'b0));
        checkOutput("stale_empty_allowin", 191'(M_allowin), 191'(1'b1));
        tick();
        applyStimulus(1'b0, bus, 1'b1, 1'b0, 1'b1, 32'hDEAD_0000);
        #1;
        checkOutput("stale_drop_mwv", 191'(MW_valid), 191'(1'b0));
        checkOutput("stale_drop_stall", 191'(Mfwd_BUS[37]), 191'(1'b1));
        tick();
        applyStimulus(1'b0, bus, 1'b1, 1'b0, 1'b1, 32'h0000_1111);
        #1;
        checkOutput("stale_use_mwv", 191'(MW_valid), 191'(1'b1));
        checkOutput("stale_use_final", 191'(MW_BUS[158:127]), 191'(32'h0000_1111));
        tick();

        applyStimulus(1'b1, bus, 1'b1, 1'b0, 1'b0, 32'h0);
        tick();
        applyStimulus(1'b0, bus, 1'b1, 1'b1, 1'b1, 32'h7777_7777);
        #1;
        checkOutput("flushok_mwv", 191'(MW_valid), 191'(1'b0));
        tick();
        runOp("flushok_next", 1'b1, 1'b1, 3'd0, 32'h0000_3004, 32'h0, 32'h55AA_55AA, 0,
              32'h55AA_55AA);

        applyStimulus(1'b1, bus, 1'b1, 1'b0, 1'b0, 32'h0);
        tick();
        applyStimulus(1'b0, bus, 1'b0, 1'b0, 1'b1, 32'h6666_6666);
        tick();
        rstn = 1'b0;
        applyStimulus(1'b0, bus, 1'b0, 1'b0, 1'b0, 32'h0);
        tick();
        #1;
        checkOutput("midrst_mwv", 191'(MW_valid), 191'(1'b0));
        checkOutput("midrst_allowin", 191'(M_allowin), 191'(1'b1));
        checkOutput("midrst_fwd_we", 191'(Mfwd_BUS[38]), 191'(1'b0));
        rstn = 1'b1;
        runOp("midrst_next", 1'b1, 1'b1, 3'd0, 32'h0000_3008, 32'h0, 32'h0BAD_F00D, 1,
              32'h0BAD_F00D);

        doReset();
        runRandom(400);

        $display("%0d/%0d checks passed", passCount, checkCount);
        $finish;
    end

endmodule
